// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx between NUM_REQ byte-stream requesters.
// A grant is held until the byte flagged last has left the transmitter, or until the owner stalls too long.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int IDLE_TIMEOUT = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(IDLE_TIMEOUT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   g_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               last_q;

  logic [7:0]       data_arr [NUM_REQ];
  logic             any_valid;
  logic [IDX_W-1:0] win_idx;
  logic             g_valid;
  logic [7:0]       g_data;
  logic             g_last;
  logic             accept;
  logic             timeout_hit;
  logic [IDX_W-1:0] next_ptr;

  // Unpack the flat data bus so the owner's byte can be picked by index.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[8*i +: 8];
    end
  end

  // Rotating priority: walk downward so the last hit is the closest one at or above ptr.
  always_comb begin
    logic [IDX_W-1:0] cand;
    // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
    any_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (req_valid[cand]) begin
        any_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign g_valid     = req_valid[g_q];
  assign g_data      = data_arr[g_q];
  assign g_last      = req_last[g_q];
  assign accept      = (state_q == S_FETCH) && g_valid && !tx_busy;
  assign timeout_hit = (state_q == S_FETCH) && !accept && (cnt_q == CNT_LAST);
  assign next_ptr    = (g_q == IDX_LAST) ? '0 : g_q + 1'b1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_valid) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (accept)           state_d = S_START;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_START: begin
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (tx_busy) state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!tx_busy) state_d = last_q ? S_IDLE : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: handshake and start strobe decode straight from the registered state.
  always_comb begin
    req_ready = '0;
    tx_start  = 1'b0;
    if (state_q == S_FETCH && !tx_busy) begin
      req_ready[g_q] = req_valid[g_q];
    end
    if (state_q == S_START) begin
      tx_start = 1'b1;
    end
  end

  // Grant, pointer, idle counter and byte holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      g_q         <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      tx_data     <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_valid) begin
            g_q     <= win_idx;
            grant_q <= NUM_REQ'(1) << win_idx;
            cnt_q   <= '0;
          end
        end
        S_FETCH: begin
          if (accept) begin
            tx_data <= g_data;
            last_q  <= g_last;
          end else if (timeout_hit) begin
            grant_q     <= '0;
            timeout_err <= 1'b1;
            ptr_q       <= next_ptr;
          end else if (cnt_q != '1) begin
            // Saturating so a counter narrower than the timeout can never wrap back to zero.
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT_LO: begin
          if (!tx_busy) begin
            if (last_q) begin
              grant_q <= '0;
              ptr_q   <= next_ptr;
            end else begin
              cnt_q <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two requesters, a 10-cycle-busy uart_tx model,
// and event logs (start pulses, grant changes, timeouts) compared against hand-derived values.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 2;
  localparam int IDLE_TIMEOUT = 16;
  localparam int BUSY_LEN     = 10;
  localparam int MISSING      = -1000;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 timeout_err;

  logic force_busy = 1'b0;
  int   busy_cnt = 0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  beat_t q0[$];
  beat_t q1[$];

  logic [7:0]         sdata[$];
  int                 scyc[$];
  logic [NUM_REQ-1:0] glog[$];
  int                 gcyc[$];
  int                 to_cnt = 0;
  int                 to_cyc = MISSING;
  int                 vr0 = MISSING;
  int                 vr1 = MISSING;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: busy rises the cycle after tx_start and lasts BUSY_LEN cycles.
  always @(posedge clk) begin
    if (tx_start)           busy_cnt <= BUSY_LEN;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || force_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    if (r == 0) q0.push_back(b);
    else        q1.push_back(b);
  endtask

  task automatic clear_logs();
    sdata.delete();
    scyc.delete();
    glog.delete();
    gcyc.delete();
    to_cnt = 0;
    to_cyc = MISSING;
    vr0    = MISSING;
    vr1    = MISSING;
  endtask

  function automatic int sd(input int i);
    if (i < sdata.size()) return int'(sdata[i]);
    return MISSING;
  endfunction

  function automatic int sc(input int i);
    if (i < scyc.size()) return scyc[i];
    return MISSING;
  endfunction

  function automatic int gl(input int i);
    if (i < glog.size()) return int'(glog[i]);
    return MISSING;
  endfunction

  function automatic int gc(input int i);
    if (i < gcyc.size()) return gcyc[i];
    return MISSING;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    q0.delete();
    q1.delete();
    force_busy = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2 clear_logs();
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (!done && n < max_cyc) begin
      @(negedge clk);
      n++;
      done = (q0.size() == 0) && (q1.size() == 0) && (grant == '0) && !tx_busy;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Requester driver: presents queue heads, pops a beat after an edge where req_ready was high.
  initial begin
    logic [NUM_REQ-1:0] rdy_seen;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      rdy_seen = req_ready;
      @(posedge clk);
      #1;
      if (rdy_seen[0] && q0.size() != 0) void'(q0.pop_front());
      if (rdy_seen[1] && q1.size() != 0) void'(q1.pop_front());
      req_valid[0]   = (q0.size() != 0);
      req_data[7:0]  = (q0.size() != 0) ? q0[0].data : 8'h00;
      req_last[0]    = (q0.size() != 0) ? q0[0].last : 1'b0;
      req_valid[1]   = (q1.size() != 0);
      req_data[15:8] = (q1.size() != 0) ? q1[0].data : 8'h00;
      req_last[1]    = (q1.size() != 0) ? q1[0].last : 1'b0;
    end
  end

  // Event monitor, sampled mid-cycle.
  initial begin
    logic [NUM_REQ-1:0] prev_grant;
    logic [NUM_REQ-1:0] prev_valid;
    prev_grant = '0;
    prev_valid = '0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        sdata.push_back(tx_data);
        scyc.push_back(cyc);
      end
      if (timeout_err) begin
        to_cnt++;
        to_cyc = cyc;
      end
      if (grant != prev_grant) begin
        glog.push_back(grant);
        gcyc.push_back(cyc);
      end
      prev_grant = grant;
      if (req_valid[0] && !prev_valid[0] && vr0 == MISSING) vr0 = cyc;
      if (req_valid[1] && !prev_valid[1] && vr1 == MISSING) vr1 = cyc;
      prev_valid = req_valid;
    end
  end

  initial begin
    int n;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_data", 32'(tx_data), 32'h00);
    check("rst_timeout", 32'(timeout_err), 32'd0);

    // Single 3-byte packet from requester 0.
    do_reset();
    @(negedge clk);
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b0);
    push(0, 8'h43, 1'b1);
    wait_done("t1", 400);
    check("t1_nstart", 32'(sdata.size()), 32'd3);
    check("t1_d0", 32'(sd(0)), 32'h41);
    check("t1_d1", 32'(sd(1)), 32'h42);
    check("t1_d2", 32'(sd(2)), 32'h43);
    check("t1_grant_val", 32'(gl(0)), 32'h1);
    check("t1_grant_lat", 32'(gc(0) - vr0), 32'd1);
    check("t1_start0_lat", 32'(sc(0) - vr0), 32'd2);
    check("t1_start1_lat", 32'(sc(1) - vr0), 32'd15);
    check("t1_start2_lat", 32'(sc(2) - vr0), 32'd28);
    check("t1_release_val", 32'(gl(1)), 32'h0);
    check("t1_release_lat", 32'(gc(1) - vr0), 32'd40);

    // Simultaneous 2-byte packets: requester 0 first, then requester 1.
    do_reset();
    @(negedge clk);
    push(0, 8'h10, 1'b0);
    push(0, 8'h11, 1'b1);
    push(1, 8'h20, 1'b0);
    push(1, 8'h21, 1'b1);
    wait_done("t2", 600);
    check("t2_nstart", 32'(sdata.size()), 32'd4);
    check("t2_d0", 32'(sd(0)), 32'h10);
    check("t2_d1", 32'(sd(1)), 32'h11);
    check("t2_d2", 32'(sd(2)), 32'h20);
    check("t2_d3", 32'(sd(3)), 32'h21);
    check("t2_g0", 32'(gl(0)), 32'h1);
    check("t2_g1", 32'(gl(1)), 32'h0);
    check("t2_g2", 32'(gl(2)), 32'h2);
    check("t2_g3", 32'(gl(3)), 32'h0);
    check("t2_handover", 32'(gc(2) - gc(1)), 32'd1);

    // Fairness: requester 1 slots in right after requester 0's current packet.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(0, 8'(48 + i), 1'b1);
    repeat (5) @(negedge clk);
    push(1, 8'h40, 1'b1);
    wait_done("t3", 600);
    check("t3_nstart", 32'(sdata.size()), 32'd5);
    check("t3_d0", 32'(sd(0)), 32'h30);
    check("t3_d1", 32'(sd(1)), 32'h40);
    check("t3_d2", 32'(sd(2)), 32'h31);
    check("t3_d3", 32'(sd(3)), 32'h32);
    check("t3_d4", 32'(sd(4)), 32'h33);
    check("t3_g2", 32'(gl(2)), 32'h2);

    // Timeout: requester 1 sends one non-last byte then goes quiet.
    do_reset();
    @(negedge clk);
    push(1, 8'h55, 1'b0);
    wait_done("t4", 300);
    check("t4_to_count", 32'(to_cnt), 32'd1);
    check("t4_to_lat", 32'(to_cyc - vr1), 32'd30);
    check("t4_grant_val", 32'(gl(0)), 32'h2);
    check("t4_revoke_val", 32'(gl(1)), 32'h0);
    check("t4_revoke_cyc", 32'(gc(1) - to_cyc), 32'd0);
    @(negedge clk);
    push(0, 8'h60, 1'b1);
    push(1, 8'h61, 1'b1);
    wait_done("t4b", 300);
    check("t4_ptr_first", 32'(sd(1)), 32'h60);
    check("t4_ptr_second", 32'(sd(2)), 32'h61);

    // Reset asserted while waiting for busy to fall.
    do_reset();
    @(negedge clk);
    push(0, 8'h5A, 1'b0);
    push(0, 8'h5B, 1'b1);
    n = 0;
    while (sdata.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_started", 32'(sdata.size()), 32'd1);
    repeat (4) @(negedge clk);
    check("t5_pre_grant", 32'(grant), 32'h1);
    check("t5_pre_data", 32'(tx_data), 32'h5A);
    #2 rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    check("t5_rst_grant", 32'(grant), 32'h0);
    check("t5_rst_start", 32'(tx_start), 32'h0);
    check("t5_rst_data", 32'(tx_data), 32'h00);
    check("t5_rst_ready", 32'(req_ready), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2 clear_logs();
    @(negedge clk);
    push(1, 8'h71, 1'b1);
    wait_done("t5", 200);
    check("t5_nstart", 32'(sdata.size()), 32'd1);
    check("t5_d0", 32'(sd(0)), 32'h71);
    check("t5_grant", 32'(gl(0)), 32'h2);

    // Busy already high when the grant lands.
    do_reset();
    @(negedge clk);
    force_busy = 1'b1;
    push(0, 8'h7E, 1'b1);
    n = 0;
    while (grant == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_granted", 32'(grant), 32'h1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t6_blocked%0d", i), 32'(req_ready), 32'h0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk);
    #1 force_busy = 1'b0;
    @(negedge clk);
    check("t6_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    check("t6_start", 32'(tx_start), 32'h1);
    check("t6_data", 32'(tx_data), 32'h7E);
    wait_done("t6", 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
